// File: rtl/rv_bus_pkg.sv
// Shared bus definitions for the core, the soc memory and mem_bus_arbiter.
package rv_bus_pkg;

  localparam int unsigned BUS_ADDR_W = 32;
  localparam int unsigned BUS_DATA_W = 64;

  localparam logic M_FETCH = 1'b0;
  localparam logic M_DATA  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY0,
    BUSY1
  } arb_state_t;

endpackage

// File: rtl/arb_watchdog.sv
// Busy-cycle counter for mem_bus_arbiter; pulses timeout in the TIMEOUT-th
// BUSY cycle that has no s_ack. Used only when ARB_WATCHDOG_EN is defined.
module arb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic busy,
  input  logic s_ack,
  output logic timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || start) begin
      count <= '0;
    end else if (busy && !s_ack && !timeout) begin
      count <= count + 1'b1;
    end
  end

  assign timeout = busy && !s_ack && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Fetch/load-store arbiter for the single soc memory port; data side wins
// unless the fetch side has waited MAX_STREAK grants. Watchdog: ARB_WATCHDOG_EN.
module mem_bus_arbiter
  import rv_bus_pkg::*;
#(
  parameter int unsigned ADDR_W     = BUS_ADDR_W,
  parameter int unsigned DATA_W     = BUS_DATA_W,
  parameter int unsigned MAX_STREAK = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic [ADDR_W-1:0]   m0_addr,
  output logic                m0_ack,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_err,
  input  logic                m1_req,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic                m1_we,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_ack,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_err,
  output logic                s_req,
  output logic [ADDR_W-1:0]   s_addr,
  output logic                s_we,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_ack,
  input  logic [DATA_W-1:0]   s_rdata
);

  arb_state_t state, state_next;
  logic [3:0] streak;
  logic       grant;
  logic       winner;
  logic       done;
  logic       timeout;
  logic       streak_full;

  assign streak_full = (streak == 4'(MAX_STREAK));
  assign done        = s_ack || timeout;

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    winner     = M_DATA;
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant      = 1'b1;
          winner     = (m1_req && !(m0_req && streak_full)) ? M_DATA : M_FETCH;
          state_next = (winner == M_DATA) ? BUSY1 : BUSY0;
        end
      end
      BUSY0, BUSY1: begin
        if (done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      streak  <= '0;
      s_req   <= 1'b0;
      s_addr  <= '0;
      s_we    <= 1'b0;
      s_wdata <= '0;
      s_wstrb <= '0;
    end else begin
      state <= state_next;
      if (grant) begin
        s_req <= 1'b1;
        if (winner == M_DATA) begin
          s_addr  <= m1_addr;
          s_we    <= m1_we;
          s_wdata <= m1_wdata;
          s_wstrb <= m1_wstrb;
          // Only a win over a waiting fetch counts toward the streak.
          if (!m0_req)          streak <= '0;
          else if (!streak_full) streak <= streak + 4'd1;
        end else begin
          s_addr  <= m0_addr;
          s_we    <= 1'b0;
          s_wdata <= '0;
          s_wstrb <= '0;
          streak  <= '0;
        end
      end else if (state != IDLE && done) begin
        s_req <= 1'b0;
      end
    end
  end

`ifdef ARB_WATCHDOG_EN
  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .start   (grant),
    .busy    (state != IDLE),
    .s_ack   (s_ack),
    .timeout (timeout)
  );
`else
  localparam int unsigned timeout_unused = TIMEOUT;
  assign timeout = 1'b0;
`endif

  // Completion is combinational from s_ack; reset masks it so a hung bus
  // cannot leak an ack while rst is asserted.
  assign m0_ack   = !rst && (state == BUSY0) && done;
  assign m1_ack   = !rst && (state == BUSY1) && done;
  assign m0_err   = m0_ack && timeout;
  assign m1_err   = m1_ack && timeout;
  assign m0_rdata = (m0_ack && !timeout) ? s_rdata : '0;
  assign m1_rdata = (m1_ack && !timeout) ? s_rdata : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: transaction-level model with a
// per-cycle compare process, a memory responder and directed scenarios.
module tb_mem_bus_arbiter;

  localparam int MAXS = 4;
  localparam int TMO  = 8;
`ifdef ARB_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0;
  logic [31:0] m0_addr = '0;
  logic        m0_ack;
  logic [63:0] m0_rdata;
  logic        m0_err;
  logic        m1_req = 1'b0;
  logic [31:0] m1_addr = '0;
  logic        m1_we = 1'b0;
  logic [63:0] m1_wdata = '0;
  logic [7:0]  m1_wstrb = '0;
  logic        m1_ack;
  logic [63:0] m1_rdata;
  logic        m1_err;
  logic        s_req;
  logic [31:0] s_addr;
  logic        s_we;
  logic [63:0] s_wdata;
  logic [7:0]  s_wstrb;
  logic        s_ack = 1'b0;
  logic [63:0] s_rdata = '0;

  mem_bus_arbiter #(
    .ADDR_W(32),
    .DATA_W(64),
    .MAX_STREAK(MAXS),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .s_req(s_req), .s_addr(s_addr), .s_we(s_we), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ack(s_ack), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: acks mem_k cycles after s_req rises, or on force_ack.
  int mem_k      = 2;
  bit mem_on     = 1'b1;
  bit force_ack  = 1'b0;
  int mem_cnt    = 0;

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 64'h00000013_00100093;
    return {~a, a};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (s_req && mem_on) mem_cnt++;
      else mem_cnt = 0;
      s_ack   = force_ack || (mem_on && s_req && mem_cnt == mem_k + 1);
      s_rdata = s_ack ? mem_word(s_addr) : 64'h5A5A_5A5A_5A5A_5A5A;
    end
  end

  // Model: who owns the bus, how long it has been outstanding, the fetch
  // starvation count and the request latched at grant time.
  int          owner = -1;
  int          busy_n = 0;
  int          streak_m = 0;
  int          win;
  bit          model_live = 1'b0;
  logic [31:0] e_addr = '0;
  logic        e_we = 1'b0;
  logic [63:0] e_wdata = '0;
  logic [7:0]  e_wstrb = '0;

  function automatic bit wd_fire();
    return WD && owner >= 0 && busy_n + 1 == TMO && !s_ack;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        owner = -1; busy_n = 0; streak_m = 0;
        e_addr = '0; e_we = 1'b0; e_wdata = '0; e_wstrb = '0;
        model_live = 1'b1;
      end else if (owner < 0) begin
        win = -1;
        if (m0_req && m1_req) win = (streak_m >= MAXS) ? 0 : 1;
        else if (m1_req)      win = 1;
        else if (m0_req)      win = 0;
        if (win == 1) begin
          streak_m = m0_req ? ((streak_m < MAXS) ? streak_m + 1 : MAXS) : 0;
          e_addr = m1_addr; e_we = m1_we; e_wdata = m1_wdata; e_wstrb = m1_wstrb;
        end else if (win == 0) begin
          streak_m = 0;
          e_addr = m0_addr; e_we = 1'b0; e_wdata = '0; e_wstrb = '0;
        end
        owner  = win;
        busy_n = 0;
      end else begin
        if (s_ack || wd_fire()) owner = -1;
        else busy_n++;
      end
    end
  end

  initial begin
    bit          fire;
    bit          a0, a1;
    forever begin
      @(negedge clk);
      if (model_live) begin
        fire = wd_fire();
        a0 = !rst && owner == 0 && (s_ack || fire);
        a1 = !rst && owner == 1 && (s_ack || fire);
        chk("m0_ack",   m0_ack,   a0);
        chk("m1_ack",   m1_ack,   a1);
        chk("m0_err",   m0_err,   a0 && fire);
        chk("m1_err",   m1_err,   a1 && fire);
        chk("m0_rdata", m0_rdata, (a0 && !fire) ? s_rdata : 64'h0);
        chk("m1_rdata", m1_rdata, (a1 && !fire) ? s_rdata : 64'h0);
        chk("s_req",    s_req,    owner >= 0);
        chk("s_addr",   s_addr,   e_addr);
        chk("s_we",     s_we,     e_we);
        chk("s_wdata",  s_wdata,  e_wdata);
        chk("s_wstrb",  s_wstrb,  e_wstrb);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  int got;
  int exp_seq[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    // Reset state
    do_reset();
    sample();
    chk("reset_s_req",  s_req,  1'b0);
    chk("reset_s_addr", s_addr, 64'h0);
    chk("reset_m0_ack", m0_ack, 1'b0);
    chk("reset_m1_ack", m1_ack, 1'b0);

    // Single fetch, k=2
    do_reset();
    mem_k = 2; mem_on = 1'b1;
    m0_req = 1'b1; m0_addr = 32'h8000_0000;
    sample(); chk("fetch_c0_s_req", s_req, 1'b0);
    tick(); sample();
    chk("fetch_c1_s_req", s_req, 1'b1);
    chk("fetch_c1_s_we", s_we, 1'b0);
    chk("fetch_c1_s_addr", s_addr, 64'h8000_0000);
    tick(); sample(); chk("fetch_c2_m0_ack", m0_ack, 1'b0);
    tick(); sample();
    chk("fetch_c3_m0_ack", m0_ack, 1'b1);
    chk("fetch_c3_m0_rdata", m0_rdata, 64'h00000013_00100093);
    tick(); m0_req = 1'b0;
    sample(); chk("fetch_c4_s_req", s_req, 1'b0);

    // Simultaneous requests: write wins, fetch follows after one IDLE cycle
    do_reset();
    m0_req = 1'b1; m0_addr = 32'h8000_0040;
    m1_req = 1'b1; m1_addr = 32'h8000_1000; m1_we = 1'b1;
    m1_wdata = 64'h0000_0000_DEAD_BEEF; m1_wstrb = 8'h0F;
    tick(); sample();
    chk("both_c1_s_we", s_we, 1'b1);
    chk("both_c1_s_addr", s_addr, 64'h8000_1000);
    chk("both_c1_s_wstrb", s_wstrb, 64'h0F);
    chk("both_c1_s_wdata", s_wdata, 64'hDEAD_BEEF);
    tick(); tick(); sample();
    chk("both_c3_m1_ack", m1_ack, 1'b1);
    chk("both_c3_m0_ack", m0_ack, 1'b0);
    tick(); m1_req = 1'b0; m1_we = 1'b0;
    sample(); chk("both_c4_idle", s_req, 1'b0);
    tick(); sample();
    chk("both_c5_s_addr", s_addr, 64'h8000_0040);
    chk("both_c5_s_wstrb", s_wstrb, 64'h0);
    tick(); tick(); sample();
    chk("both_c7_m0_ack", m0_ack, 1'b1);
    chk("both_c7_m0_rdata", m0_rdata, 64'h7FFF_FFBF_8000_0040);
    tick(); m0_req = 1'b0;

    // Starvation: both held, k=1
    do_reset();
    mem_k = 1;
    m0_req = 1'b1; m0_addr = 32'h8000_0100;
    m1_req = 1'b1; m1_addr = 32'h8000_3000; m1_we = 1'b0;
    for (int t = 0; t < 10; t++) begin
      got = -1;
      for (int c = 0; c < 20 && got < 0; c++) begin
        sample();
        if (m1_ack) got = 1;
        else if (m0_ack) got = 0;
        tick();
      end
      chk($sformatf("starve_grant%0d", t), got, exp_seq[t]);
    end
    m0_req = 1'b0; m1_req = 1'b0;

    // Memory never acks an m1 read
    do_reset();
    mem_on = 1'b0;
    m1_req = 1'b1; m1_addr = 32'h8000_2000; m1_we = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick(); sample();
      if (c < 8) chk($sformatf("hang_c%0d_m1_ack", c), m1_ack, 1'b0);
    end
`ifdef ARB_WATCHDOG_EN
    chk("wd_c8_m1_ack", m1_ack, 1'b1);
    chk("wd_c8_m1_err", m1_err, 1'b1);
    chk("wd_c8_m1_rdata", m1_rdata, 64'h0);
    tick(); m1_req = 1'b0;
    sample(); chk("wd_c9_s_req", s_req, 1'b0);
`else
    chk("hang_c8_m1_ack", m1_ack, 1'b0);
    for (int c = 9; c <= 20; c++) tick();
    sample(); chk("hang_c20_s_req", s_req, 1'b1);
    m1_req = 1'b0;
`endif
    do_reset();
    mem_on = 1'b1;

    // Reset mid-BUSY1, late ack one cycle after
    mem_on = 1'b0;
    m1_req = 1'b1; m1_addr = 32'h8000_4000;
    tick(); sample(); chk("rst_c1_s_req", s_req, 1'b1);
    tick(); rst = 1'b1; m1_req = 1'b0;
    sample();
    chk("rst_c2_m1_ack", m1_ack, 1'b0);
    chk("rst_c2_s_req", s_req, 1'b1);
    tick(); rst = 1'b0; force_ack = 1'b1;
    sample();
    chk("rst_c3_m1_ack", m1_ack, 1'b0);
    chk("rst_c3_s_req", s_req, 1'b0);
    tick(); force_ack = 1'b0;
    sample(); chk("rst_c4_s_req", s_req, 1'b0);
    mem_on = 1'b1;

    // Spurious s_ack in IDLE, then a normal fetch still works
    tick(); force_ack = 1'b1;
    sample();
    chk("spur_m0_ack", m0_ack, 1'b0);
    chk("spur_m1_ack", m1_ack, 1'b0);
    tick(); force_ack = 1'b0;
    sample(); chk("spur_after_s_req", s_req, 1'b0);
    tick(); m0_req = 1'b1; m0_addr = 32'h8000_0200;
    tick(); sample();
    chk("spur_next_s_req", s_req, 1'b1);
    chk("spur_next_s_addr", s_addr, 64'h8000_0200);
    got = -1;
    for (int c = 0; c < 10 && got < 0; c++) begin
      sample();
      if (m0_ack) got = 0;
      tick();
    end
    chk("spur_next_m0_done", got, 0);
    m0_req = 1'b0;

    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter sharing the single memory port of the soc between the core's instruction-fetch unit (master 0, read-only) and load/store unit (master 1, read/write). Sits between the riscv core and the soc memory (rom/ram) inside soc. Data accesses win by default, with an anti-starvation streak limit that guarantees fetch progress. An optional watchdog terminates hung transactions with an error.

## Interface
Parameters:
- ADDR_W, 32: address width.
- DATA_W, 64: data width (RV64).
- MAX_STREAK, 4: consecutive master-1 grants allowed while master 0 waits; range 1..15.
- TIMEOUT, 255: watchdog limit in cycles; only used with the watchdog compiled in.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- m0_req  in  1  fetch request; held with m0_addr until m0_ack.
- m0_addr  in  ADDR_W  fetch address.
- m0_ack  out  1  one-cycle completion pulse for master 0.
- m0_rdata  out  DATA_W  fetch data; valid only while m0_ack is high.
- m0_err  out  1  timeout error; qualified by m0_ack.
- m1_req  in  1  data request; m1_addr, m1_we, m1_wdata and m1_wstrb are held until m1_ack.
- m1_addr  in  ADDR_W  data address.
- m1_we  in  1  1 = write.
- m1_wdata  in  DATA_W  write data.
- m1_wstrb  in  DATA_W/8  byte strobes.
- m1_ack  out  1  completion pulse for master 1.
- m1_rdata  out  DATA_W  load data; valid only while m1_ack is high.
- m1_err  out  1  timeout error; qualified by m1_ack.
- s_req  out  1  request to memory; held until s_ack.
- s_addr  out  ADDR_W  registered address.
- s_we  out  1  registered write enable.
- s_wdata  out  DATA_W  registered write data.
- s_wstrb  out  DATA_W/8  registered byte strobes.
- s_ack  in  1  memory completion pulse.
- s_rdata  in  DATA_W  memory read data; valid with s_ack.

## Operation
FSM states:
- IDLE: evaluate requests.
  - Neither master requesting: stay in IDLE.
  - Only one requesting: grant it.
  - Both requesting: grant master 1 unless streak == MAX_STREAK, in which case grant master 0.
  - On grant: register the winner's addr/we/wdata/wstrb into the s_* outputs. Master 0 always drives we=0 and wstrb=0.
  - Next state is BUSY0 or BUSY1.
- BUSY0 / BUSY1: s_req = 1.
  - On s_ack: the granted master's ack = 1 and rdata = s_rdata, combinationally. Next state is IDLE.
  - The non-granted master's ack stays 0.
- Streak counter (4 bit):
  - Increments on a master-1 grant when m0_req is high.
  - Clears on any master-0 grant, or on a master-1 grant with m0_req low.
  - Saturates at MAX_STREAK.
- Boundary conditions:
  - s_ack in IDLE: ignored.
  - A master dropping req before its ack is a protocol violation. The arbiter still completes the transaction and drives the ack.
  - Reset mid-transaction: state returns to IDLE, streak is cleared, and s_req drops at that edge. A late s_ack is then ignored.
- Reset values:
  - Registered: s_req, s_we, s_addr, s_wdata, s_wstrb, streak, and state = IDLE.
  - All m*_ack and m*_err outputs are 0 in reset.
  - m*_rdata read 0 whenever the corresponding ack is 0.

## Timing
- Request seen in IDLE at edge N: s_req is high from cycle N+1.
- Memory acks k cycles after s_req rises: the master's ack occurs in that same cycle (zero added return latency).
- The FSM is in IDLE for exactly one cycle after every ack. Back-to-back throughput is therefore one transaction per (k+2) cycles.
- A master that keeps req high after its ack issues a new request. It is arbitrated in the following IDLE cycle.

## Configuration
- ARB_WATCHDOG_EN defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without s_ack.
  - On reaching TIMEOUT, the granted master gets ack = 1, err = 1 and rdata = 0. s_req drops and the FSM goes to IDLE.
  - If s_ack arrives in the same cycle, it wins: normal completion with err = 0.
- Not defined: m0_err and m1_err are tied 0, and BUSY waits for s_ack indefinitely.

## Structure
- Shared package rv_bus_pkg:
  - state enum (IDLE, BUSY0, BUSY1);
  - master-id constants;
  - the default ADDR_W and DATA_W localparams, shared with the core and the soc memory.
- One sub-module: arb_watchdog (counter plus TIMEOUT compare, output timeout pulse). It is instantiated only under ARB_WATCHDOG_EN.

## Test plan
- Single fetch: m0_req with addr 0x80000000, memory acks with k=2 and s_rdata 0x00000013_00100093. Required: s_req rises the cycle after m0_req, m0_ack pulses 3 cycles after m0_req with that data, and s_we = 0.
- Simultaneous requests: m0 and m1 (write 0xDEADBEEF to 0x80001000, wstrb 0x0F) both asserted. Required: m1 is served first, then after one IDLE cycle m0 is served.
- Starvation: m1_req held continuously and m0_req held, MAX_STREAK = 4. Required: 4 m1 grants, then an m0 grant, then the streak restarts.
- Watchdog (macro defined, TIMEOUT = 8): memory never acks an m1 read. Required: m1_ack and m1_err high in the 8th BUSY cycle, m1_rdata 0, s_req low the next cycle. The same test without the macro shows s_req stuck high.
- Reset mid-BUSY1 with an ack arriving 1 cycle later. Required: no m1_ack, s_req 0 after the reset edge, and the late s_ack is ignored.
- Spurious s_ack while in IDLE. Required: no master ack and no state change.
